// File: rtl/oam_dma.sv
// oam_dma: OAM DMA engine behind a CPU register; copies LENGTH bytes from page {V,8'h00} into OAM.
// Build option OAM_DMA_RESTART_EN: a register write while busy restarts the transfer.
module oam_dma #(
    parameter logic [15:0] REG_ADDR    = 16'hff46,
    parameter logic [15:0] OAM_BASE    = 16'hfe00,
    parameter int unsigned LENGTH      = 160,
    parameter int unsigned START_DELAY = 1
) (
    input  logic        clockgb,
    input  logic        resetn,
    input  logic [15:0] address,
    input  logic [7:0]  indata,
    output logic [7:0]  outdata,
    input  logic        load,
    input  logic        store,
    output logic [15:0] dma_address,
    input  logic [7:0]  dma_rdata,
    output logic [7:0]  dma_wdata,
    output logic        dma_load,
    output logic        dma_store,
    output logic        busy
);
    typedef enum logic [1:0] {StIdle, StWait, StRead, StWrite} state_e;

    localparam logic [7:0] LastIdx = 8'(LENGTH - 1);
    localparam logic [3:0] DlyInit = 4'(START_DELAY);

    state_e     r_state;
    logic [7:0] r_src;
    logic [7:0] r_xfer_src;
    logic [7:0] r_idx;
    logic [3:0] r_dly;
    logic [7:0] r_outdata;
    logic       r_busy;
    logic       w_reg_wr;
    logic       w_reg_rd;
    logic       w_start;

    assign w_reg_wr = store && (address == REG_ADDR);
    assign w_reg_rd = load && (address == REG_ADDR);
`ifdef OAM_DMA_RESTART_EN
    assign w_start = w_reg_wr;
`else
    assign w_start = w_reg_wr && (r_state == StIdle);
`endif

    // r_xfer_src holds the page for the running transfer; r_src is the CPU-visible register.
    always_ff @(posedge clockgb or negedge resetn) begin
        if (!resetn) begin
            r_state    <= StIdle;
            r_src      <= 8'h00;
            r_xfer_src <= 8'h00;
            r_idx      <= 8'h00;
            r_dly      <= 4'h0;
            r_outdata  <= 8'h00;
            r_busy     <= 1'b0;
        end else begin
            r_outdata <= w_reg_rd ? r_src : 8'h00;
            if (w_reg_wr) begin
                r_src <= indata;
            end
            if (w_start) begin
                r_xfer_src <= indata;
                r_idx      <= 8'h00;
                r_dly      <= DlyInit;
                r_busy     <= 1'b1;
                r_state    <= (START_DELAY == 0) ? StRead : StWait;
            end else begin
                unique case (r_state)
                    StWait: begin
                        r_dly <= r_dly - 4'd1;
                        if (r_dly < 4'd2) begin
                            r_state <= StRead;
                        end
                    end
                    StRead: begin
                        r_state <= StWrite;
                    end
                    StWrite: begin
                        if (r_idx == LastIdx) begin
                            r_state <= StIdle;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_state <= StRead;
                        end
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

    // 8-bit index never carries into the page byte, so the read address is a plain concat.
    always_comb begin
        dma_load    = 1'b0;
        dma_store   = 1'b0;
        dma_address = 16'h0000;
        dma_wdata   = 8'h00;
        unique case (r_state)
            StRead: begin
                dma_load    = 1'b1;
                dma_address = {r_xfer_src, r_idx};
            end
            StWrite: begin
                dma_store   = 1'b1;
                dma_address = OAM_BASE + {8'h00, r_idx};
                dma_wdata   = dma_rdata;
            end
            default: begin
                dma_load = 1'b0;
            end
        endcase
    end

    assign outdata = r_outdata;
    assign busy    = r_busy;

endmodule

// File: tb/tb_oam_dma.sv
// tb_oam_dma: self-checking bench for oam_dma; a flat page-copy model predicts every OAM write.
module tb_oam_dma;
    localparam int unsigned Length   = 160;
    localparam int unsigned Delay    = 1;
    localparam logic [15:0] RegAddr  = 16'hff46;
    localparam logic [15:0] OamBase  = 16'hfe00;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] address;
    logic [7:0]  indata;
    logic        load;
    logic        store;
    logic [7:0]  outdata;
    logic [15:0] dma_address;
    logic [7:0]  dma_rdata;
    logic [7:0]  dma_wdata;
    logic        dma_load;
    logic        dma_store;
    logic        busy;

    logic [15:0] address2;
    logic [7:0]  indata2;
    logic        load2;
    logic        store2;
    logic [7:0]  outdata2;
    logic [15:0] dma_address2;
    logic [7:0]  dma_rdata2;
    logic [7:0]  dma_wdata2;
    logic        dma_load2;
    logic        dma_store2;
    logic        busy2;

    always #5 clk = ~clk;

    oam_dma u_dut (
        .clockgb    (clk),
        .resetn     (resetn),
        .address    (address),
        .indata     (indata),
        .outdata    (outdata),
        .load       (load),
        .store      (store),
        .dma_address(dma_address),
        .dma_rdata  (dma_rdata),
        .dma_wdata  (dma_wdata),
        .dma_load   (dma_load),
        .dma_store  (dma_store),
        .busy       (busy)
    );

    oam_dma #(.LENGTH(1), .START_DELAY(0)) u_dut2 (
        .clockgb    (clk),
        .resetn     (resetn),
        .address    (address2),
        .indata     (indata2),
        .outdata    (outdata2),
        .load       (load2),
        .store      (store2),
        .dma_address(dma_address2),
        .dma_rdata  (dma_rdata2),
        .dma_wdata  (dma_wdata2),
        .dma_load   (dma_load2),
        .dma_store  (dma_store2),
        .busy       (busy2)
    );

    logic [7:0]  mem [65536];
    logic [15:0] rd_q [$];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    bit          ev_q [$];
    int          busy_cnt = 0;
    int          both_hi  = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          alt_bad;
    int          n_wait;

    typedef struct {
        logic        st;
        logic        ld;
        logic [15:0] a;
        logic [7:0]  d;
        logic [7:0]  exp;
    } reg_vec_t;
    reg_vec_t tbl [10];

    // Source memory: read data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (dma_load)  dma_rdata  <= mem[dma_address];
        if (dma_load2) dma_rdata2 <= mem[dma_address2];
    end

    always @(negedge clk) begin
        if (dma_load && dma_store) both_hi <= both_hi + 1;
        if (dma_load) begin
            rd_q.push_back(dma_address);
            ev_q.push_back(1'b1);
        end
        if (dma_store) begin
            wa_q.push_back(dma_address);
            wd_q.push_back(dma_wdata);
            ev_q.push_back(1'b0);
        end
        if (busy) busy_cnt <= busy_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wa_q.delete();
        wd_q.delete();
        ev_q.delete();
        busy_cnt = 0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        address = a;
        indata  = d;
        store   = 1'b1;
        @(negedge clk);
        store   = 1'b0;
        address = 16'h0000;
        indata  = 8'h00;
    endtask

    task automatic cpu_read_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
        @(negedge clk);
        address = a;
        load    = 1'b1;
        @(posedge clk);
        #1;
        chk(name, 32'(outdata), 32'(exp));
        @(negedge clk);
        load    = 1'b0;
        address = 16'h0000;
    endtask

    task automatic wait_idle(input string name);
        n_wait = 0;
        while (busy && n_wait < 2000) begin
            @(negedge clk);
            n_wait++;
        end
        chk({name, " completes"}, 32'(busy), 32'd0);
    endtask

    // Reference: byte i of page v lands at OAM_BASE+i, read from {v,8'h00}+i.
    task automatic check_copy(input string name, input logic [7:0] v, input int wb, input int rb);
        logic [15:0] s;
        chk({name, " write count"}, 32'(wa_q.size() - wb), Length);
        chk({name, " read count"}, 32'(rd_q.size() - rb), Length);
        for (int i = 0; i < int'(Length); i++) begin
            s = {v, 8'h00} + 16'(i);
            if (wb + i < wa_q.size()) begin
                chk($sformatf("%s waddr[%0d]", name, i), 32'(wa_q[wb + i]), 32'(OamBase + 16'(i)));
                chk($sformatf("%s wdata[%0d]", name, i), 32'(wd_q[wb + i]), 32'(mem[s]));
            end
            if (rb + i < rd_q.size()) begin
                chk($sformatf("%s raddr[%0d]", name, i), 32'(rd_q[rb + i]), 32'(s));
            end
        end
    endtask

    task automatic run_xfer(input string name, input logic [7:0] v);
        clear_logs();
        cpu_write(RegAddr, v);
        wait_idle(name);
        check_copy(name, v, 0, 0);
        chk({name, " busy cycles"}, 32'(busy_cnt), Delay + 2 * Length);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'hc000 + 16'(i)] = 8'(i) ^ 8'h5a;

        resetn = 1'b0;
        address = 16'h0000; indata = 8'h00; load = 1'b0; store = 1'b0;
        address2 = 16'h0000; indata2 = 8'h00; load2 = 1'b0; store2 = 1'b0;
        #12;
        chk("reset busy", 32'(busy), 0);
        chk("reset dma_load", 32'(dma_load), 0);
        chk("reset dma_store", 32'(dma_store), 0);
        chk("reset dma_address", 32'(dma_address), 0);
        chk("reset dma_wdata", 32'(dma_wdata), 0);
        chk("reset outdata", 32'(outdata), 0);
        @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: page C0 with C000+i = i^5A
        run_xfer("t1", 8'hc0);
        chk("t1 wdata[0]", 32'(wd_q.size() > 0 ? wd_q[0] : 8'hxx), 32'h5a);
        chk("t1 wdata[159]", 32'(wd_q.size() > 159 ? wd_q[159] : 8'hxx), 32'(8'd159 ^ 8'h5a));
        alt_bad = 0;
        for (int k = 0; k < ev_q.size(); k++) if (ev_q[k] != (k % 2 == 0)) alt_bad++;
        chk("t1 strobe alternation", 32'(alt_bad), 0);
        chk("t1 strobe events", 32'(ev_q.size()), 2 * Length);

        // Test 2: register port vectors; outdata checked one cycle after each row
        tbl[0] = '{1'b1, 1'b0, 16'hff46, 8'h81, 8'h00};
        tbl[1] = '{1'b0, 1'b1, 16'hff46, 8'h00, 8'h81};
        tbl[2] = '{1'b0, 1'b1, 16'hff45, 8'h00, 8'h00};
        tbl[3] = '{1'b0, 1'b0, 16'hff46, 8'h00, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 16'hff46, 8'h3c, 8'h00};
        tbl[5] = '{1'b0, 1'b1, 16'hff46, 8'h00, 8'h3c};
        tbl[6] = '{1'b0, 1'b1, 16'hff47, 8'h00, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 16'hff45, 8'h99, 8'h00};
        tbl[8] = '{1'b0, 1'b1, 16'hff46, 8'h00, 8'h3c};
        tbl[9] = '{1'b0, 1'b1, 16'h0000, 8'h00, 8'h00};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            store = tbl[k].st; load = tbl[k].ld; address = tbl[k].a; indata = tbl[k].d;
            @(posedge clk);
            #1;
            chk($sformatf("t2 reg row %0d", k), 32'(outdata), 32'(tbl[k].exp));
        end
        @(negedge clk);
        store = 1'b0; load = 1'b0; address = 16'h0000; indata = 8'h00;
        wait_idle("t2");
        repeat (2) @(negedge clk);

        // Test 3: top page, no wrap into 0x0000
        run_xfer("t3", 8'hff);
        chk("t3 last read", 32'(rd_q.size() > 0 ? rd_q[rd_q.size() - 1] : 16'h0), 32'hff9f);
        chk("t3 last write", 32'(wa_q.size() > 0 ? wa_q[wa_q.size() - 1] : 16'h0), 32'hfe9f);

        // Random pages against the model
        for (int r = 0; r < 4; r++) run_xfer($sformatf("rnd%0d", r), 8'($urandom_range(0, 255)));

        // Test 4: second write 50 cycles into a transfer
        clear_logs();
        cpu_write(RegAddr, 8'hc0);
        repeat (50) @(negedge clk);
        cpu_write(RegAddr, 8'hd0);
        wait_idle("t4");
`ifdef OAM_DMA_RESTART_EN
        check_copy("t4", 8'hd0, wa_q.size() - int'(Length), rd_q.size() - int'(Length));
`else
        check_copy("t4", 8'hc0, 0, 0);
        chk("t4 busy cycles", 32'(busy_cnt), Delay + 2 * Length);
`endif
        cpu_read_chk("t4 readback", RegAddr, 8'hd0);

        // Test 5: reset at byte 80
        clear_logs();
        cpu_write(RegAddr, 8'h40);
        n_wait = 0;
        while (wa_q.size() < 80 && n_wait < 1000) begin
            @(negedge clk);
            n_wait++;
        end
        chk("t5 reached byte 80", 32'(wa_q.size() >= 80), 1);
        #2 resetn = 1'b0;
        #1;
        chk("t5 busy async", 32'(busy), 0);
        chk("t5 dma_load async", 32'(dma_load), 0);
        chk("t5 dma_store async", 32'(dma_store), 0);
        chk("t5 dma_address async", 32'(dma_address), 0);
        @(negedge clk);
        resetn = 1'b1;
        clear_logs();
        repeat (40) @(negedge clk);
        chk("t5 no reads after release", 32'(rd_q.size()), 0);
        chk("t5 no writes after release", 32'(wa_q.size()), 0);
        chk("t5 no busy after release", 32'(busy_cnt), 0);
        cpu_read_chk("t5 src cleared", RegAddr, 8'h00);

        // Test 6: START_DELAY=0, LENGTH=1 instance
        @(negedge clk);
        address2 = RegAddr; indata2 = 8'hc0; store2 = 1'b1;
        @(negedge clk);
        store2 = 1'b0; address2 = 16'h0000;
        chk("t6 c1 busy", 32'(busy2), 1);
        chk("t6 c1 dma_load", 32'(dma_load2), 1);
        chk("t6 c1 dma_store", 32'(dma_store2), 0);
        chk("t6 c1 address", 32'(dma_address2), 32'hc000);
        @(negedge clk);
        chk("t6 c2 busy", 32'(busy2), 1);
        chk("t6 c2 dma_load", 32'(dma_load2), 0);
        chk("t6 c2 dma_store", 32'(dma_store2), 1);
        chk("t6 c2 address", 32'(dma_address2), 32'hfe00);
        chk("t6 c2 wdata", 32'(dma_wdata2), 32'h5a);
        @(negedge clk);
        chk("t6 c3 busy", 32'(busy2), 0);
        chk("t6 c3 strobes", 32'({dma_load2, dma_store2}), 0);
        chk("t6 outdata idle", 32'(outdata2), 0);

        chk("strobes never both high", 32'(both_hi), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
